// File: rtl/evt_dma_pkg.sv
// evt_dma_pkg: default widths and P-stage state encoding shared by the event DMA packetizer.
package evt_dma_pkg;
    localparam int DATA_WIDTH_DEF    = 64;
    localparam int LEN_WIDTH_DEF     = 16;
    localparam int TIMEOUT_WIDTH_DEF = 32;
    localparam logic [1:0] P_EMPTY      = 2'd0;
    localparam logic [1:0] P_HOLD       = 2'd1;
    localparam logic [1:0] P_CLOSE_PEND = 2'd2;
endpackage

// File: rtl/evt_dma_idle_timer.sv
// evt_dma_idle_timer: counts idle cycles and flags when the count reaches a programmable limit.
module evt_dma_idle_timer
    import evt_dma_pkg::*;
#(
    parameter int WIDTH_G = TIMEOUT_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               clear_i,
    input  logic               run_i,
    input  logic [WIDTH_G-1:0] limit_i,
    output logic               expired_o
);
    logic [WIDTH_G-1:0] cnt_q, cnt_d;
    logic [WIDTH_G:0]   cnt_inc;

    // Expiry covers the current idle cycle, so a limit of N closes on the Nth idle cycle.
    assign cnt_inc   = {1'b0, cnt_q} + {{WIDTH_G{1'b0}}, 1'b1};
    assign expired_o = (limit_i != '0) & (cnt_inc >= {1'b0, limit_i});
    assign cnt_d     = clear_i ? '0 : (run_i & ~expired_o) ? cnt_inc[WIDTH_G-1:0] : cnt_q;

    always_ff @(posedge clk or negedge arst_n)
        if (!arst_n) cnt_q <= '0;
        else         cnt_q <= cnt_d;
endmodule

// File: rtl/evt_dma_packetizer.sv
// evt_dma_packetizer: groups an event stream into DMA S2MM packets, closing on length,
// flush, disable or idle timeout. P holds the beat whose TLAST is still undecided.
module evt_dma_packetizer
    import evt_dma_pkg::*;
#(
    parameter int DATA_WIDTH_G    = DATA_WIDTH_DEF,
    parameter int LEN_WIDTH_G     = LEN_WIDTH_DEF,
    parameter int TIMEOUT_WIDTH_G = TIMEOUT_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       enable_i,
    input  logic                       flush_i,
    input  logic [LEN_WIDTH_G-1:0]     packet_length_i,
    input  logic [TIMEOUT_WIDTH_G-1:0] timeout_i,
    output logic                       in_ready_o,
    input  logic                       in_valid_i,
    input  logic [DATA_WIDTH_G-1:0]    in_data_i,
    input  logic                       out_ready_i,
    output logic                       out_valid_o,
    output logic [DATA_WIDTH_G-1:0]    out_data_o,
    output logic                       out_last_o,
    output logic [31:0]                pkt_count_o,
    output logic                       busy_o
);
    logic [1:0]              p_state_q, p_state_d;
    logic [DATA_WIDTH_G-1:0] p_data_q, p_data_d, o_data_q, o_data_d;
    logic                    o_valid_q, o_valid_d, o_last_q, o_last_d;
    logic [LEN_WIDTH_G:0]    beat_cnt_q, beat_cnt_d, beat_base;
    logic [LEN_WIDTH_G-1:0]  len_q, len_d;
    logic [31:0]             pkt_cnt_q, pkt_cnt_d;
    logic                    p_occ, o_free, accept, len_hit, tmo_exp, close_now, move;

    assign p_occ      = p_state_q != P_EMPTY;
    assign o_free     = ~o_valid_q | out_ready_i;
    assign in_ready_o = arst_n & enable_i & ~flush_i & (~p_occ | o_free);
    assign accept     = in_valid_i & in_ready_o;
    assign len_hit    = beat_cnt_q == {1'b0, len_q};
    // An accept coinciding with idle expiry wins, so the pending beat leaves without TLAST.
    assign close_now  = p_occ & ((p_state_q == P_CLOSE_PEND) | len_hit | flush_i | ~enable_i |
                                 (tmo_exp & ~accept));
    assign move       = p_occ & o_free & (accept | close_now);
    assign beat_base  = (move & close_now) ? '0 : beat_cnt_q;

    always_comb begin
        p_state_d  = accept ? P_HOLD : move ? P_EMPTY : close_now ? P_CLOSE_PEND : p_state_q;
        p_data_d   = accept ? in_data_i : p_data_q;
        o_valid_d  = move | (o_valid_q & ~out_ready_i);
        o_data_d   = move ? p_data_q : o_data_q;
        o_last_d   = move ? close_now : o_last_q;
        beat_cnt_d = accept ? beat_base + {{LEN_WIDTH_G{1'b0}}, 1'b1} : beat_base;
        len_d      = (accept & (beat_base == '0)) ?
                     ((packet_length_i == '0) ? LEN_WIDTH_G'(1) : packet_length_i) : len_q;
        pkt_cnt_d  = pkt_cnt_q + {31'd0, o_valid_q & out_ready_i & o_last_q};
    end

    always_ff @(posedge clk or negedge arst_n)
        if (!arst_n) begin
            p_state_q  <= P_EMPTY;
            p_data_q   <= '0;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            o_last_q   <= 1'b0;
            beat_cnt_q <= '0;
            len_q      <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            p_state_q  <= p_state_d;
            p_data_q   <= p_data_d;
            o_valid_q  <= o_valid_d;
            o_data_q   <= o_data_d;
            o_last_q   <= o_last_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end

    evt_dma_idle_timer #(.WIDTH_G(TIMEOUT_WIDTH_G)) u_idle_timer (
        .clk       (clk),
        .arst_n    (arst_n),
        .clear_i   (accept | ~p_occ),
        .run_i     (p_occ),
        .limit_i   (timeout_i),
        .expired_o (tmo_exp)
    );

    assign out_valid_o = o_valid_q;
    assign out_data_o  = o_data_q;
    assign out_last_o  = o_last_q;
    assign pkt_count_o = pkt_cnt_q;
    assign busy_o      = p_occ | o_valid_q;
endmodule

// File: tb/tb_evt_dma_packetizer.sv
// tb_evt_dma_packetizer: directed stimulus with a scoreboard queue checked by a separate output monitor.
module tb_evt_dma_packetizer;
    logic        clk, arst_n, enable_i, flush_i, in_valid_i, in_ready_o;
    logic        out_ready_i, out_valid_o, out_last_o, busy_o;
    logic [15:0] packet_length_i;
    logic [31:0] timeout_i, pkt_count_o;
    logic [63:0] in_data_i, out_data_o;
    logic        rdy_fix, rand_en, rnd;
    int          cyc = 0, n_pass = 0, n_total = 0;
    int          t0, t1;
    logic [64:0] sb[$];

    evt_dma_packetizer dut (
        .clk             (clk),
        .arst_n          (arst_n),
        .enable_i        (enable_i),
        .flush_i         (flush_i),
        .packet_length_i (packet_length_i),
        .timeout_i       (timeout_i),
        .in_ready_o      (in_ready_o),
        .in_valid_i      (in_valid_i),
        .in_data_i       (in_data_i),
        .out_ready_i     (out_ready_i),
        .out_valid_o     (out_valid_o),
        .out_data_o      (out_data_o),
        .out_last_o      (out_last_o),
        .pkt_count_o     (pkt_count_o),
        .busy_o          (busy_o)
    );

    assign out_ready_i = rand_en ? rnd : rdy_fix;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        rnd = 1;
        forever begin
            @(posedge clk);
            #1 rnd = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic expect_beat(input logic [63:0] d, input logic l);
        sb.push_back({l, d});
    endtask

    task automatic send(input logic [63:0] d);
        logic a = 0;
        int   n = 0;
        in_valid_i = 1;
        in_data_i  = d;
        while (!a && n < 200) begin
            @(negedge clk);
            a = in_ready_o;
            @(posedge clk);
            #1 n++;
        end
        in_valid_i = 0;
        if (!a) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_last(output int c);
        c = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (out_valid_o && out_last_o) begin
                c = cyc;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 400 && (busy_o || sb.size() != 0); n++) @(negedge clk);
        chk("idle_busy", busy_o, 0);
        chk("sb_drained", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_flush();
        flush_i = 1;
        @(posedge clk);
        #1 flush_i = 0;
    endtask

    initial begin
        logic [64:0] e;
        forever begin
            @(negedge clk);
            if (arst_n && out_valid_o && out_ready_i) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_beat: got last=%0b data=%0h, expected none", out_last_o, out_data_o);
                end else begin
                    e = sb.pop_front();
                    chk("beat", {out_last_o, out_data_o}, e);
                end
            end
        end
    end

    initial begin
        arst_n = 0; enable_i = 1; flush_i = 0; in_valid_i = 0; in_data_i = 0;
        packet_length_i = 4; timeout_i = 0; rdy_fix = 1; rand_en = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_out_last", out_last_o, 0);
        chk("rst_out_data", out_data_o, 0);
        chk("rst_pkt_count", pkt_count_o, 0);
        chk("rst_busy", busy_o, 0);
        arst_n = 1;
        @(posedge clk);
        #1;

        // Length 4, 8 back-to-back beats at full rate.
        for (int i = 0; i < 8; i++) expect_beat(64'h100 + 64'(i), (i % 4) == 3);
        t0 = cyc;
        for (int i = 0; i < 8; i++) send(64'h100 + 64'(i));
        chk("throughput_cycles", cyc - t0, 8);
        wait_idle();
        chk("pkt_count_len4", pkt_count_o, 2);

        // Idle timeout of 10 closes a 3-beat packet.
        packet_length_i = 16; timeout_i = 10;
        for (int i = 0; i < 3; i++) expect_beat(64'h200 + 64'(i), i == 2);
        for (int i = 0; i < 3; i++) send(64'h200 + 64'(i));
        t0 = cyc;
        wait_last(t1);
        chk("timeout_latency", t1 - t0, 10);
        wait_idle();
        chk("pkt_count_timeout", pkt_count_o, 3);

        // Random backpressure, 64 beats of length-8 packets.
        packet_length_i = 8; timeout_i = 0; rand_en = 1;
        for (int i = 0; i < 64; i++) expect_beat(64'h3000 + 64'(i), (i % 8) == 7);
        for (int i = 0; i < 64; i++) send(64'h3000 + 64'(i));
        rand_en = 0;
        wait_idle();
        chk("pkt_count_random", pkt_count_o, 11);

        // Flush after 5 beats, then a flush with nothing pending.
        packet_length_i = 16;
        for (int i = 0; i < 5; i++) expect_beat(64'h40 + 64'(i), i == 4);
        for (int i = 0; i < 5; i++) send(64'h40 + 64'(i));
        pulse_flush();
        wait_idle();
        pulse_flush();
        repeat (5) @(posedge clk);
        #1;
        chk("empty_flush_valid", out_valid_o, 0);
        chk("empty_flush_busy", busy_o, 0);
        chk("pkt_count_flush", pkt_count_o, 12);

        // Accept in the same cycle the timeout expires: no last, timer restarts.
        timeout_i = 6;
        expect_beat(64'h50, 0);
        expect_beat(64'h51, 1);
        send(64'h50);
        repeat (5) @(posedge clk);
        #1 send(64'h51);
        t0 = cyc;
        wait_last(t1);
        chk("restart_latency", t1 - t0, 6);
        wait_idle();
        chk("pkt_count_coincide", pkt_count_o, 13);

        // Reset with two beats held; they must never appear.
        timeout_i = 0; packet_length_i = 4; rdy_fix = 0;
        send(64'h60);
        send(64'h61);
        arst_n = 0;
        #1;
        chk("arst_out_valid", out_valid_o, 0);
        chk("arst_out_last", out_last_o, 0);
        chk("arst_out_data", out_data_o, 0);
        chk("arst_pkt_count", pkt_count_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_in_ready", in_ready_o, 0);
        @(posedge clk);
        #1 arst_n = 1; rdy_fix = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) expect_beat(64'h70 + 64'(i), i == 3);
        for (int i = 0; i < 4; i++) send(64'h70 + 64'(i));
        wait_idle();
        chk("pkt_count_post_rst", pkt_count_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/evt_dma_packetizer.md
EVT_DMA_PACKETIZER -- requirements
Module: evt_dma_packetizer

Interface
REQ-001 SHALL have parameter DATA_WIDTH_G, default 64, event bus width in bits.
REQ-002 SHALL have parameter LEN_WIDTH_G, default 16, width of packet_length_i.
REQ-003 SHALL have parameter TIMEOUT_WIDTH_G, default 32, width of timeout_i.
REQ-004 SHALL have one clock and an asynchronous active-low reset:
- clk  in  1  sole clock; all logic on the rising edge.
- arst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have the following ports:
- enable_i  in  1  packetizer enable.
- flush_i  in  1  one-cycle pulse; closes the current packet.
- packet_length_i  in  LEN_WIDTH_G  beats per packet; 0 is treated as 1.
- timeout_i  in  TIMEOUT_WIDTH_G  idle cycles before a forced close; 0 disables the timeout.
- in_ready_o  out  1  upstream ready.
- in_valid_i  in  1  upstream valid.
- in_data_i  in  DATA_WIDTH_G  upstream event data.
- out_ready_i  in  1  DMA S2MM ready.
- out_valid_o  out  1  DMA S2MM valid.
- out_data_o  out  DATA_WIDTH_G  DMA S2MM data.
- out_last_o  out  1  end-of-packet marker (TLAST).
- pkt_count_o  out  32  number of completed packets; wraps modulo 2^32.
- busy_o  out  1  high while any beat is held internally.

Function
REQ-006 SHALL hold data in two stages: P (pending; last not yet decided) and O (output register driving out_*).
REQ-007 SHALL transfer a beat on in_valid_i & in_ready_o, and on out_valid_o & out_ready_i.
REQ-008 SHALL drive in_ready_o = enable_i & ~flush_i & (P empty | O empty | out_ready_i).
REQ-009 SHALL load each accepted beat into P on the next edge; if P was occupied, the old P moves to O with last=0 in the same edge.
REQ-010 SHALL count accepted beats of the current packet in beat_cnt (LEN_WIDTH_G+1 bits); beat_cnt resets to 0 when a beat leaves P with last=1.
REQ-011 SHALL latch packet_length_i when the first beat of a packet is accepted; changes mid-packet take effect from the next packet.
REQ-012 SHALL move P to O with last=1 on the edge after P holds beat number packet_length (length close), provided O is empty or draining.
REQ-013 SHALL count idle cycles while P is occupied and no beat is accepted; the counter clears on every accept.
REQ-014 SHALL close the packet (P to O, last=1) when timeout_i != 0 and the idle count reaches timeout_i.
REQ-015 SHALL close the packet on flush_i, or on enable_i low, when P is occupied; when P is empty, flush_i has no effect (no zero-length packet).
REQ-016 SHALL, when an accept and a timeout expiry fall in the same cycle, take the accept; the pending beat then moves to O with last=0.
REQ-017 SHALL keep a close request pending while O is full and not draining; P SHALL NOT be overwritten in that state.
REQ-018 SHALL hold out_data_o and out_last_o stable while out_valid_o=1 and out_ready_i=0.
REQ-019 SHALL increment pkt_count_o on every output transfer with out_last_o=1.
REQ-020 SHALL drive busy_o = P occupied | out_valid_o.
REQ-021 SHALL give a minimum latency of 2 edges from acceptance of the last beat of a packet to out_valid_o; sustained throughput SHALL be 1 beat/cycle.

Reset
REQ-022 SHALL, while arst_n=0, drive in_ready_o=0, out_valid_o=0, out_last_o=0, out_data_o=0, pkt_count_o=0, busy_o=0, and clear P, beat_cnt and the idle counter.
REQ-023 SHALL discard held beats on reset mid-packet; no TLAST is emitted for them.

Structure
REQ-024 SHALL place the default widths and the P-stage state encoding (EMPTY, HOLD, CLOSE_PEND) in the shared package evt_dma_pkg.
REQ-025 SHALL implement the idle counter as sub-module evt_dma_idle_timer (inputs: clear, run, limit; output: expired).

Verification
REQ-026 SHALL verify: packet_length=4, 8 back-to-back beats, out_ready=1 -> last on beats 4 and 8, pkt_count=2.
REQ-027 SHALL verify: packet_length=16, timeout=10, 3 beats then idle -> beat 3 emitted with last exactly 10 idle cycles after the third accept.
REQ-028 SHALL verify: packet_length=8, out_ready toggling 50% random, 64 beats -> data in order, no loss or duplication, 8 lasts.
REQ-029 SHALL verify: 5 beats, flush_i pulse, then a flush with P empty -> one packet of 5 beats, no extra output beat.
REQ-030 SHALL verify: timeout expiry coincident with an accept -> no last on the old beat; the timer restarts.
REQ-031 SHALL verify: arst_n asserted with 2 beats held -> all outputs 0 immediately; first post-reset packet starts at beat_cnt=0.
